neuron_preact_mac: RTL and testbench

Sequential multiply-accumulate stage that computes one neuron's pre-activation, z = bias + sum(x_i * w_i), over N_INPUTS streamed beats.
It converts the signed accumulator to the 8-bit unsigned Q2.6 code expected by the downstream sigmoid lookup stage (code k represents k/64), clamping to 0..255.
It sits directly upstream of the sigmoid LUT: its z output drives the LUT's 8-bit z input, and h comes back from the LUT unchanged.

---
 rtl/neuron_preact_mac.sv | 141 ++++++++++++++
 tb/tb_neuron_preact_mac.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_preact_mac.sv
// Streamed multiply-accumulate for one neuron pre-activation, z = bias + sum(x_i * w_i),
// converted to a clamped unsigned Q2.6 code for the downstream sigmoid lookup.
module neuron_preact_mac #(
    parameter int unsigned N_INPUTS = 4,
    parameter int unsigned ACC_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bias,
    input  logic [7:0] x,
    input  logic [7:0] w,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] z,
    output logic       z_valid,
    input  logic       z_ready,
    output logic       neg,
    output logic       sat
);

    localparam int unsigned CntW = (N_INPUTS > 1) ? $clog2(N_INPUTS + 1) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [7:0]               z_q, z_d;
    logic                     neg_q, neg_d;
    logic                     sat_q, sat_d;
    logic                     z_valid_q, z_valid_d;

    logic signed [16:0]       prod_full;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  r;
    logic                     accept;
    logic                     final_beat;

    // x is unsigned, so it gets a zero MSB before the signed multiply.
    assign prod_full = $signed({1'b0, x}) * $signed(w);
    assign prod_ext  = {{(ACC_W - 17){prod_full[16]}}, prod_full};
    // Q2.5 bias aligned to the Q2.13 product scale.
    assign bias_ext  = {{(ACC_W - 16){bias[7]}}, bias, 8'd0};

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        z_d        = z_q;
        neg_d      = neg_q;
        sat_d      = sat_q;
        z_valid_d  = z_valid_q;
        in_ready   = (state_q != StHold);
        accept     = in_valid && in_ready;
        final_beat = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d = bias_ext + prod_ext;
                    cnt_d = CntW'(1);
                    if (N_INPUTS == 1) begin
                        final_beat = 1'b1;
                        state_d    = StHold;
                    end else begin
                        state_d = StAccum;
                    end
                end
            end
            StAccum: begin
                if (accept) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(N_INPUTS - 1)) begin
                        final_beat = 1'b1;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (z_ready) begin
                    z_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Drop the 7 extra fraction bits (Q.13 -> Q.6), flooring toward -inf.
        r = acc_d >>> 7;
        if (final_beat) begin
            z_valid_d = 1'b1;
            if (r[ACC_W-1]) begin
                z_d   = 8'd0;
                neg_d = 1'b1;
                sat_d = 1'b0;
            end else if (|r[ACC_W-1:8]) begin
                z_d   = 8'd255;
                neg_d = 1'b0;
                sat_d = 1'b1;
            end else begin
                z_d   = r[7:0];
                neg_d = 1'b0;
                sat_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            cnt_q     <= '0;
            z_q       <= 8'd0;
            neg_q     <= 1'b0;
            sat_q     <= 1'b0;
            z_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            neg_q     <= neg_d;
            sat_q     <= sat_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign z       = z_q;
    assign neg     = neg_q;
    assign sat     = sat_q;
    assign z_valid = z_valid_q;

endmodule

// File: tb/tb_neuron_preact_mac.sv
// Directed bench for neuron_preact_mac: vector table of 4-beat neurons plus
// backpressure, gap and mid-evaluation reset sequences.
module tb_neuron_preact_mac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] bias, x, w;
    logic       in_valid, in_ready;
    logic [7:0] z;
    logic       z_valid, z_ready, neg, sat;

    int checks = 0;
    int errors = 0;

    neuron_preact_mac #(
        .N_INPUTS(4),
        .ACC_W   (20)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bias    (bias),
        .x       (x),
        .w       (w),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .z       (z),
        .z_valid (z_valid),
        .z_ready (z_ready),
        .neg     (neg),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]      bias;
        logic [3:0][7:0] x;
        logic [3:0][7:0] w;
        logic [7:0]      ez;
        logic            en;
        logic            es;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mk(input logic [7:0] b,
                                input logic [7:0] x0, x1, x2, x3,
                                input logic [7:0] w0, w1, w2, w3,
                                input logic [7:0] ez, input logic en, es);
        vec_t v;
        v.bias = b;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.ez = ez; v.en = en; v.es = es;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic send_beat(input logic [7:0] b, input logic [7:0] xi, input logic [7:0] wi);
        int t = 0;
        bias = b; x = xi; w = wi; in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int gap, input bit handshake);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("z_valid_early", z_valid, 0);
            // Later beats carry a different bias to show it is sampled only once.
            send_beat((i == 0) ? v.bias : (v.bias ^ 8'h5a), v.x[i], v.w[i]);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    z_ready = 1'b1;
                    @(posedge clk); #1;
                end
                z_ready = 1'b0;
            end
        end
        check("z_valid_latency", z_valid, 1);
        check("z", z, v.ez);
        check("neg", neg, v.en);
        check("sat", sat, v.es);
        check("in_ready_hold", in_ready, 0);
        if (handshake) begin
            z_ready = 1'b1;
            @(posedge clk); #1;
            z_ready = 1'b0;
            check("z_valid_drop", z_valid, 0);
            check("in_ready_idle", in_ready, 1);
            check("z_retained", z, v.ez);
        end
    endtask

    initial begin
        rst_n = 1'b0; bias = '0; x = '0; w = '0; in_valid = 1'b0; z_ready = 1'b0;

        vecs[0] = mk(8'd0, 8'd128, 8'd128, 8'd128, 8'd128,
                     8'd32, 8'd32, 8'd32, 8'd32, 8'd128, 1'b0, 1'b0);
        vecs[1] = mk(8'd0, 8'd128, 8'd128, 8'd128, 8'd128,
                     8'hE0, 8'hE0, 8'hE0, 8'hE0, 8'd0, 1'b1, 1'b0);
        vecs[2] = mk(8'd127, 8'd255, 8'd255, 8'd255, 8'd255,
                     8'd127, 8'd127, 8'd127, 8'd127, 8'd255, 1'b0, 1'b1);
        vecs[3] = mk(8'd32, 8'd0, 8'd0, 8'd0, 8'd0,
                     8'h80, 8'h80, 8'h80, 8'h80, 8'd64, 1'b0, 1'b0);
        vecs[4] = mk(8'hFF, 8'd0, 8'd0, 8'd0, 8'd0,
                     8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 1'b1, 1'b0);
        // 12800 - 1000 + 1650 + 765 + 2560 = 16775 -> r = 131
        vecs[5] = mk(8'd10, 8'd200, 8'd100, 8'd50, 8'd255,
                     8'd64, 8'hF6, 8'd33, 8'd3, 8'd131, 1'b0, 1'b0);
        // 32512 + 128 = 32640 -> r = 255, largest unclamped code
        vecs[6] = mk(8'd127, 8'd128, 8'd0, 8'd0, 8'd0,
                     8'd1, 8'd0, 8'd0, 8'd0, 8'd255, 1'b0, 1'b0);
        // 32512 + 256 = 32768 -> r = 256, first clamped code
        vecs[7] = mk(8'd127, 8'd128, 8'd0, 8'd0, 8'd0,
                     8'd2, 8'd0, 8'd0, 8'd0, 8'd255, 1'b0, 1'b1);

        #3;
        check("rst_z", z, 0);
        check("rst_z_valid", z_valid, 0);
        check("rst_neg", neg, 0);
        check("rst_sat", sat, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0, 1'b1);

        // Idle gaps between beats, with stray z_ready pulses while z_valid is low.
        run_vec(vecs[5], 2, 1'b1);

        // Backpressure, then the next neuron follows the handshake directly.
        run_vec(vecs[0], 0, 1'b0);
        bias = 8'd0; x = 8'd64; w = 8'd32; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_z_valid", z_valid, 1);
            check("bp_z", z, 128);
        end
        z_ready = 1'b1;
        @(posedge clk); #1;
        z_ready = 1'b0;
        check("bp_z_valid_drop", z_valid, 0);
        check("bp_in_ready_back", in_ready, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) send_beat(8'd0, 8'd64, 8'd32);
        check("bp_next_z_valid", z_valid, 1);
        check("bp_next_z", z, 64);
        z_ready = 1'b1;
        @(posedge clk); #1;
        z_ready = 1'b0;

        // Reset after two beats of a saturating neuron; the fresh neuron must be clean.
        send_beat(8'd127, 8'd255, 8'd127);
        send_beat(8'd127, 8'd255, 8'd127);
        rst_n = 1'b0;
        #2;
        check("mid_rst_z", z, 0);
        check("mid_rst_z_valid", z_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(mk(8'd0, 8'd64, 8'd64, 8'd64, 8'd64,
                   8'd32, 8'd32, 8'd32, 8'd32, 8'd64, 1'b0, 1'b0), 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
